store_op_buffer: RTL
====================

# store_op_buffer

Elastic buffer between the vector core's store-operand output and the memory-side store port. It captures operands offered with the core's valid/grant protocol, holds them in a `Depth`-entry FIFO, and presents them in order on a valid/ready memory interface. It groups consecutive beats into fixed-length bursts with a `last` marker. It decouples lane write-back timing from memory back-pressure, so the core never stalls on a single slow memory cycle.

## Interface
Parameters:
- `Depth`, 4, number of FIFO entries; power of two, ≥2.
- `BurstLen`, 4, beats per burst; ≥1; `mem_last_o` marks every `BurstLen`-th beat.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `store_op_valid_i`  in  1  core offers an operand.
- `store_op_i`  in  `vrf_data_t`  operand data.
- `store_op_gnt_o`  out  1  operand accepted this cycle.
- `mem_valid_o`  out  1  head entry available.
- `mem_data_o`  out  `vrf_data_t`  head entry data.
- `mem_last_o`  out  1  head beat is the final beat of its burst.
- `mem_ready_i`  in  1  memory takes the head beat.
- `count_o`  out  `$clog2(Depth+1)`  current occupancy.
- `full_o`  out  1  `count_o == Depth`.
- `empty_o`  out  1  `count_o == 0`.

## Operation
- Push: `store_op_gnt_o = store_op_valid_i && !full_o`.
  - `gnt` is never asserted without `valid`, per the core protocol.
  - The core holds `valid` and data stable until granted.
  - `gnt` has no combinational dependency on `mem_ready_i`.
- Pop: occurs when `mem_valid_o && mem_ready_i`.
  - `mem_valid_o = !empty_o`.
  - `mem_data_o` is the FIFO head, read directly from storage.
- Simultaneous push and pop (not full, not empty): `count` is unchanged and both pointers advance.
- Full:
  - A push is refused even if a pop happens in the same cycle.
  - The freed slot becomes grantable the next cycle.
- Empty: no fall-through. A pushed operand appears on `mem_*` the cycle after acceptance.
- Pointers: `$clog2(Depth)` bits each, wrapping modulo `Depth`. `count` is tracked separately to distinguish full from empty.
- Burst counter `beat_q`, width `$clog2(BurstLen)` (minimum 1 bit):
  - `mem_last_o = mem_valid_o && (beat_q == BurstLen-1)`.
  - On each pop, `beat_q` increments, wrapping to 0 after `BurstLen-1`.
  - With `BurstLen == 1`, `mem_last_o == mem_valid_o`.
  - `beat_q` does not change while stalled or empty, so a burst may span idle gaps.
- Reset (asynchronous, any time, including mid-burst):
  - Pointers, `count`, and `beat_q` clear to 0; all entries are discarded.
  - Outputs go to reset values immediately: `store_op_gnt_o=0` (data-dependent only), `mem_valid_o=0`, `mem_last_o=0`, `count_o=0`, `full_o=0`, `empty_o=1`, `mem_data_o` don't-care.
- Storage array is not reset.

## Timing
- Latency from accept to head is 1 cycle when empty.
- Throughput is 1 beat/cycle in both directions simultaneously when `0 < count < Depth`.
- Handshake outputs depend only on registered state plus `store_op_valid_i` (for `gnt`). There is no ready-to-grant path.
- Memory side: once `mem_valid_o` is asserted, it stays high and `mem_data_o`/`mem_last_o` stay stable until popped or reset.

## Structure
- `vrf_data_t` comes from `core_pkg`. Add `StoreBufDepth` and `StoreBurstLen` defaults there so the core and the memory adaptor share them.
- One sub-module, `op_fifo`: generic `Depth`×`vrf_data_t` FIFO with push/pop/count/full/empty.
- The burst counter and handshake gating live in `store_op_buffer`.

## Test plan
- Single beat: one operand 0xA5…, `mem_ready_i=1` → `gnt` in cycle 0; `mem_valid_o` in cycle 1 with data 0xA5…, `mem_last_o=0`; `count_o` returns to 0 in cycle 2.
- Fill to full: 4 operands 0..3 pushed with `mem_ready_i=0` → `gnt` on 4 consecutive cycles, then `full_o=1`; a 5th offered operand sees `gnt=0` until one pop, then is granted the cycle after.
- Streaming: 16 operands 0..15 with `valid` and `ready` held high → 1 beat/cycle, data in order, `mem_last_o` on values 3, 7, 11, 15.
- Random back-pressure: `mem_ready_i` toggling at 50 % over 64 beats → order preserved, no loss or duplication, `last` on every 4th popped beat, `count_o` never above 4.
- Reset mid-burst: pop 2 beats, hold 3 entries, assert `rst_i` asynchronously → `mem_valid_o=0`, `count_o=0`, `empty_o=1` with no clock edge needed. After release, the next beat starts a fresh burst (`last` on the 4th).
- `BurstLen=1`, `Depth=2` variant: every popped beat has `mem_last_o=1`; full at 2 entries.

Source files
------------

// File: rtl/core_pkg.sv
// Shared vector-core types and store-path defaults used by the core and the memory adaptor.
package core_pkg;

  localparam int unsigned VrfDataW = 64;

  typedef logic [VrfDataW-1:0] vrf_data_t;

  localparam int unsigned StoreBufDepth = 4;
  localparam int unsigned StoreBurstLen = 4;

  // Burst beat counter width; a single-beat burst still needs one bit of state.
  function automatic int unsigned beat_width(input int unsigned burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/store_op_buffer_if.sv
// Core-side valid/grant and memory-side valid/ready signals of the store operand buffer.
interface store_op_buffer_if
  import core_pkg::*;
#(
  parameter int unsigned Depth = StoreBufDepth
) ();

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic            store_op_valid_i;
  vrf_data_t       store_op_i;
  logic            store_op_gnt_o;
  logic            mem_valid_o;
  vrf_data_t       mem_data_o;
  logic            mem_last_o;
  logic            mem_ready_i;
  logic [CntW-1:0] count_o;
  logic            full_o;
  logic            empty_o;

  // Buffer side
  modport slave (
    input  store_op_valid_i, store_op_i, mem_ready_i,
    output store_op_gnt_o, mem_valid_o, mem_data_o, mem_last_o, count_o, full_o, empty_o
  );

  // Core and memory side
  modport master (
    output store_op_valid_i, store_op_i, mem_ready_i,
    input  store_op_gnt_o, mem_valid_o, mem_data_o, mem_last_o, count_o, full_o, empty_o
  );

endinterface

// File: rtl/op_fifo.sv
// Depth-entry FIFO of vector operands; head is read straight from storage (no fall-through).
module op_fifo
  import core_pkg::*;
#(
  parameter  int unsigned Depth = StoreBufDepth,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  vrf_data_t       wdata,
  input  logic            pop,
  output vrf_data_t       rdata,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  vrf_data_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage carries no reset; only valid entries are ever presented.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally since Depth is a power of two; count separates full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/store_op_buffer.sv
// Elastic store-operand buffer: core valid/grant in, memory valid/ready out, fixed-length bursts.
module store_op_buffer
  import core_pkg::*;
#(
  parameter int unsigned Depth    = StoreBufDepth,
  parameter int unsigned BurstLen = StoreBurstLen
) (
  input logic              clk_i,
  input logic              rst_i,
  store_op_buffer_if.slave bus
);

  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned BeatW = beat_width(BurstLen);

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CntW-1:0]  count;
  vrf_data_t        head;
  logic [BeatW-1:0] beat_q;
  logic             beat_wrap;

  // Grant looks only at occupancy, never at mem_ready: a pop cannot free a slot in the same cycle.
  assign push = bus.store_op_valid_i && !full;
  assign pop  = !empty && bus.mem_ready_i;

  op_fifo #(
    .Depth (Depth)
  ) u_op_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (bus.store_op_i),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign beat_wrap = (beat_q == BeatW'(BurstLen - 1));

  // Beat position only moves on a pop, so a burst may straddle stalls and idle gaps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q <= '0;
    end else if (pop) begin
      beat_q <= beat_wrap ? '0 : beat_q + BeatW'(1);
    end
  end

  assign bus.store_op_gnt_o = push;
  assign bus.mem_valid_o    = !empty;
  assign bus.mem_data_o     = head;
  assign bus.mem_last_o     = !empty && beat_wrap;
  assign bus.count_o        = count;
  assign bus.full_o         = full;
  assign bus.empty_o        = empty;

endmodule
